// File: rtl/ras_stack_ctrl.sv
// ---------------------------------------------------------------------------
// ras_stack_ctrl
// Return-address stack storage and pointer controller for the fetch/decode
// front end. Calls push their return address, predicted returns pop it, and
// pipeline flushes roll the pointer back without touching the stored entries.
// The stack is a circular buffer: pushing into a full stack silently drops
// the oldest entry.
//
// Optional feature macro: RAS_STATS_EN (adds event statistics counters).
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   AW     return-address width
//   PTR_W  derived pointer width, $clog2(DEPTH)
//
// Ports
//   clk               in   rising-edge clock
//   rst               in   asynchronous active-high reset
//   push              in   push request (call), already gated by the pipeline
//   push_addr         in   return address to push
//   pop               in   pop request (predicted return)
//   rollback_pop_id   in   flush: undo a push made by the instruction in ID
//   rollback_push_id  in   flush: undo a pop made by the instruction in ID
//   rollback_push_ex  in   flush: undo a pop made by the instruction in EX
//   top_addr          out  entry at the top-of-stack pointer (combinational)
//   top_valid         out  stack holds at least one valid entry
//   count             out  number of valid entries, 0..DEPTH
//   overflow          out  one-cycle pulse after a push into a full stack
//   underflow         out  one-cycle pulse after a pop/net rollback on empty
//   stat_push         out  (RAS_STATS_EN) accepted pushes
//   stat_pop          out  (RAS_STATS_EN) accepted pops
//   stat_ovf          out  (RAS_STATS_EN) overflow events
//   stat_rollback     out  (RAS_STATS_EN) flush cycles
// ---------------------------------------------------------------------------
module ras_stack_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic          pop,
  input  logic          rollback_pop_id,
  input  logic          rollback_push_id,
  input  logic          rollback_push_ex,
  output logic [AW-1:0] top_addr,
  output logic          top_valid,
  output logic [PTR_W:0] count,
  output logic          overflow,
  output logic          underflow
`ifdef RAS_STATS_EN
  ,
  output logic [31:0]   stat_push,
  output logic [31:0]   stat_pop,
  output logic [15:0]   stat_ovf,
  output logic [15:0]   stat_rollback
`endif
);

  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

  logic [AW-1:0]      r_mem [DEPTH];
  logic [PTR_W-1:0]   r_tosPtr;
  logic [PTR_W:0]     r_count;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_flush;
  logic signed [2:0]  w_delta;
  logic [PTR_W+2:0]   w_deltaExt;
  logic signed [PTR_W+2:0] w_countSum;
  logic [PTR_W-1:0]   w_nextPtr;
  logic [PTR_W:0]     w_nextCount;
  logic               w_nextOverflow;
  logic               w_nextUnderflow;
  logic               w_memWe;
  logic [PTR_W-1:0]   w_memWaddr;
  logic               w_acceptPush;
  logic               w_acceptPop;

  // Net pointer movement of a flush: each undone pop moves the pointer up,
  // an undone push moves it down. Range is -1..+2, so 3 signed bits suffice.
  assign w_flush    = rollback_pop_id | rollback_push_id | rollback_push_ex;
  assign w_delta    = $signed({2'b00, rollback_push_id}) + $signed({2'b00, rollback_push_ex})
                    - $signed({2'b00, rollback_pop_id});
  assign w_deltaExt = {{PTR_W{w_delta[2]}}, w_delta};
  assign w_countSum = $signed({2'b00, r_count}) + $signed(w_deltaExt);

  // Next-state selection. A flush wins over push/pop; otherwise push+pop
  // together replaces the top entry in place, except on an empty stack where
  // there is nothing to replace and it degenerates into a plain push.
  always_comb begin
    w_nextPtr       = r_tosPtr;
    w_nextCount     = r_count;
    w_nextOverflow  = 1'b0;
    w_nextUnderflow = 1'b0;
    w_memWe         = 1'b0;
    w_memWaddr      = r_tosPtr;
    w_acceptPush    = 1'b0;
    w_acceptPop     = 1'b0;
    if (w_flush) begin
      w_nextPtr = r_tosPtr + w_deltaExt[PTR_W-1:0];
      if (w_countSum < 0) begin
        w_nextCount     = '0;
        w_nextUnderflow = 1'b1;
      end else if (w_countSum > $signed({2'b00, C_FULL})) begin
        w_nextCount = C_FULL;
      end else begin
        w_nextCount = w_countSum[PTR_W:0];
      end
    end else if (push && (!pop || r_count == '0)) begin
      w_nextPtr    = r_tosPtr + PTR_W'(1);
      w_memWe      = 1'b1;
      w_memWaddr   = r_tosPtr + PTR_W'(1);
      w_acceptPush = 1'b1;
      if (r_count == C_FULL) begin
        w_nextOverflow = 1'b1;
      end else begin
        w_nextCount = r_count + (PTR_W+1)'(1);
      end
    end else if (push && pop) begin
      w_memWe      = 1'b1;
      w_memWaddr   = r_tosPtr;
      w_acceptPush = 1'b1;
      w_acceptPop  = 1'b1;
    end else if (pop) begin
      if (r_count == '0) begin
        w_nextUnderflow = 1'b1;
      end else begin
        w_nextPtr   = r_tosPtr - PTR_W'(1);
        w_nextCount = r_count - (PTR_W+1)'(1);
        w_acceptPop = 1'b1;
      end
    end
  end

  // Pointer, occupancy and event pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tosPtr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_tosPtr    <= w_nextPtr;
      r_count     <= w_nextCount;
      r_overflow  <= w_nextOverflow;
      r_underflow <= w_nextUnderflow;
    end
  end

  // Entry storage. Pops and rollbacks never write here, which is what lets
  // a rollback recover a popped address exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_memWe) begin
      r_mem[w_memWaddr] <= push_addr;
    end
  end

  assign top_addr  = r_mem[r_tosPtr];
  assign top_valid = (r_count != '0);
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

`ifdef RAS_STATS_EN
  logic [31:0] r_statPush;
  logic [31:0] r_statPop;
  logic [15:0] r_statOvf;
  logic [15:0] r_statRollback;

  // Free-running event counters; they wrap naturally at their width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_statPush     <= '0;
      r_statPop      <= '0;
      r_statOvf      <= '0;
      r_statRollback <= '0;
    end else begin
      if (w_acceptPush)   r_statPush     <= r_statPush + 32'd1;
      if (w_acceptPop)    r_statPop      <= r_statPop + 32'd1;
      if (w_nextOverflow) r_statOvf      <= r_statOvf + 16'd1;
      if (w_flush)        r_statRollback <= r_statRollback + 16'd1;
    end
  end

  assign stat_push     = r_statPush;
  assign stat_pop      = r_statPop;
  assign stat_ovf      = r_statOvf;
  assign stat_rollback = r_statRollback;
`endif

endmodule
